// File: rtl/f1_delay_sched_pkg.sv
// -----------------------------------------------------------------------------
// f1_delay_pkg
// Shared definitions for the F1 start-light sequencer:
//   state_t    - sequencer states (IDLE, LIGHTS, DELAY)
//   LFSR_W     - width of the random-hold LFSR (taps 7,6)
//   LFSR_SEED  - value loaded into the LFSR on reset
//   lfsr_next  - one step of the maximal-length feedback (period 127)
// -----------------------------------------------------------------------------
package f1_delay_pkg;

    localparam int LFSR_W = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LIGHTS = 2'd1,
        DELAY  = 2'd2
    } state_t;

    // x^7 + x^6 + 1: shift left, feed bit6 ^ bit5 into bit0. Never reaches 0
    // from a non-zero seed.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[6] ^ q[5]};
    endfunction

endpackage

// File: rtl/f1_delay_sched_lfsr7.sv
// -----------------------------------------------------------------------------
// lfsr7
// 7-bit maximal-length LFSR used as the random hold-time source.
// Ports:
//   clk  in   clock, state updates on posedge
//   rst  in   synchronous active-high reset, reloads LFSR_SEED
//   en   in   step enable; the sequencer drops it while counting the hold
//   q    out  current LFSR state
// -----------------------------------------------------------------------------
module lfsr7
    import f1_delay_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [LFSR_W-1:0]   q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/f1_delay_sched.sv
// -----------------------------------------------------------------------------
// f1_delay_sched
// F1-style start-light sequencer. A trigger in IDLE starts the sequence; each
// tick lights one more lamp (bit0 first). The tick that lights the last lamp
// captures the LFSR as a hold time D, then D further ticks later all lamps go
// out together with a one-clock done pulse.
//
// Optional feature: define F1_DELAY_SCHED_ABORT_EN to add the abort input,
// which returns LIGHTS/DELAY to IDLE with all lamps off and no done pulse.
//
// Ports:
//   clk       in   sole clock, posedge
//   rst       in   synchronous active-high reset (also reseeds the LFSR)
//   trigger   in   start request, only looked at in IDLE
//   tick      in   one-clock strobe from the prescaler, advances the sequence
//   abort     in   (F1_DELAY_SCHED_ABORT_EN only) cancel a running sequence
//   data_out  out  lamp vector, bit0 lit first
//   busy      out  high outside IDLE; stays high during the done clock
//   done      out  one-clock pulse when the lamps go out
//   lfsr_q    out  current LFSR state
// All outputs are registered.
// -----------------------------------------------------------------------------
module f1_delay_sched
    import f1_delay_pkg::state_t, f1_delay_pkg::IDLE, f1_delay_pkg::LIGHTS,
           f1_delay_pkg::DELAY;
#(
    parameter int NUM_LIGHTS = 8,
    parameter int LFSR_W     = f1_delay_pkg::LFSR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trigger,
    input  logic                   tick,
`ifdef F1_DELAY_SCHED_ABORT_EN
    input  logic                   abort,
`endif
    output logic [NUM_LIGHTS-1:0]  data_out,
    output logic                   busy,
    output logic                   done,
    output logic [LFSR_W-1:0]      lfsr_q
);

    localparam logic [NUM_LIGHTS-1:0] LAMP_FIRST = NUM_LIGHTS'(1);
    localparam logic [LFSR_W-1:0]     CNT_ONE    = LFSR_W'(1);

    state_t                  state, state_n;
    logic [NUM_LIGHTS-1:0]   data_n;
    logic [LFSR_W-1:0]       delay_cnt, cnt_n;
    logic                    done_n;
    logic                    busy_n;
    logic                    lfsr_en;

    // The LFSR free-runs except while the hold is being counted, so the
    // value on lfsr_q during DELAY is stable.
    assign lfsr_en = (state != DELAY);

    lfsr7 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (lfsr_en),
        .q   (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_out  <= '0;
            delay_cnt <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            data_out  <= data_n;
            delay_cnt <= cnt_n;
            done      <= done_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data_out;
        cnt_n   = delay_cnt;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                // A tick coinciding with the trigger is deliberately dropped;
                // the first lamp waits for the next tick.
                data_n = '0;
                if (trigger) begin
                    state_n = LIGHTS;
                end
            end

            LIGHTS: begin
                if (tick) begin
                    data_n = (data_out << 1) | LAMP_FIRST;
                    if (&data_n) begin
                        // Zero cannot come out of the LFSR, but a zero hold
                        // would underflow the counter, so clamp it to 1.
                        cnt_n   = (lfsr_q == '0) ? CNT_ONE : lfsr_q;
                        state_n = DELAY;
                    end
                end
            end

            DELAY: begin
                if (tick) begin
                    cnt_n = delay_cnt - CNT_ONE;
                    if (delay_cnt <= CNT_ONE) begin
                        data_n  = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                data_n  = '0;
                state_n = IDLE;
            end
        endcase

`ifdef F1_DELAY_SCHED_ABORT_EN
        // Abort wins over a same-cycle tick and never produces done.
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            data_n  = '0;
            cnt_n   = '0;
            done_n  = 1'b0;
        end
`endif

        // busy is held through the done clock so it falls one clock later.
        busy_n = (state_n != IDLE) || done_n;
    end

endmodule

// File: tb/tb_f1_delay_sched.sv
// -----------------------------------------------------------------------------
// tb_f1_delay_sched
// Directed bench for f1_delay_sched (NUM_LIGHTS=8): free-running LFSR after
// reset, a full lamp sequence from a vector table with ignored triggers, the
// random hold countdown, trigger+tick collision, reset in DELAY and, when
// F1_DELAY_SCHED_ABORT_EN is defined, abort behaviour.
// -----------------------------------------------------------------------------
module tb_f1_delay_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger;
    logic       tick;
`ifdef F1_DELAY_SCHED_ABORT_EN
    logic       abort;
`endif
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic [6:0] lfsr_q;

    always #5 clk = ~clk;

    f1_delay_sched #(
        .NUM_LIGHTS (8),
        .LFSR_W     (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trigger  (trigger),
        .tick     (tick),
`ifdef F1_DELAY_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .lfsr_q   (lfsr_q)
    );

    typedef struct {
        logic       trig;
        logic       tk;
        logic [7:0] data;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t       vt[$];
    logic [6:0] lref[8];
    int         n_vec = 0;
    int         n_bad = 0;

    // Reference LFSR step: x^7 + x^6 + 1.
    function automatic logic [6:0] step7(input logic [6:0] q);
        return {q[5:0], q[6] ^ q[5]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic [7:0] d, input logic b, input logic dn);
        chk({nm, " data_out"}, 32'(data_out), 32'(d));
        chk({nm, " busy"}, 32'(busy), 32'(b));
        chk({nm, " done"}, 32'(done), 32'(dn));
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        trigger = 1'b0;
        tick    = 1'b0;
`ifdef F1_DELAY_SCHED_ABORT_EN
        abort   = 1'b0;
`endif
        clk1();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] d_exp;
        logic [6:0] frz;
        int         d;
        int         ndone;

        rst     = 1'b1;
        trigger = 1'b0;
        tick    = 1'b0;
`ifdef F1_DELAY_SCHED_ABORT_EN
        abort   = 1'b0;
`endif

        // LFSR values on the eight clocks following reset release.
        lref = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03, 7'h06};

        // Full lamp sequence: trigger, then 8 groups of three idle clocks and
        // one tick. Triggers in groups 3 and 6 land in LIGHTS and must be ignored.
        vt.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                vt.push_back('{((k == 3 || k == 6) && j == 0), 1'b0,
                               8'((1 << (k - 1)) - 1), 1'b1, 1'b0});
            end
            vt.push_back('{1'b0, 1'b1, 8'((1 << k) - 1), 1'b1, 1'b0});
        end

        // Reset state and free-running LFSR.
        do_reset();
        check_outs("reset", 8'h00, 1'b0, 1'b0);
        chk("reset lfsr_q", 32'(lfsr_q), 32'h01);
        for (int i = 0; i < 8; i++) begin
            clk1();
            chk($sformatf("free-run lfsr_q[%0d]", i), 32'(lfsr_q), 32'(lref[i]));
            check_outs($sformatf("free-run %0d", i), 8'h00, 1'b0, 1'b0);
        end

        // Lamp sequence from the table. The 8th tick edge is clock 33 after
        // reset, so the captured hold is the LFSR value 32 steps from the seed.
        do_reset();
        d_exp = 7'h01;
        for (int i = 0; i < 32; i++) d_exp = step7(d_exp);
        for (int i = 0; i < vt.size(); i++) begin
            if (i == vt.size() - 1) chk("lfsr_q at capture", 32'(lfsr_q), 32'(d_exp));
            trigger = vt[i].trig;
            tick    = vt[i].tk;
            clk1();
            check_outs($sformatf("seq vec %0d", i), vt[i].data, vt[i].bsy, vt[i].dn);
        end
        trigger = 1'b0;
        tick    = 1'b0;

        // Hold countdown: LFSR frozen at the value after capture, lamps out on
        // the D-th tick, triggers in DELAY ignored, exactly one done pulse.
        frz   = step7(d_exp);
        d     = (d_exp == 7'h00) ? 1 : int'(d_exp);
        ndone = 0;
        for (int t = 1; t <= d; t++) begin
            trigger = (t % 2 == 1);
            tick    = 1'b0;
            clk1();
            chk($sformatf("delay lfsr frozen t%0d", t), 32'(lfsr_q), 32'(frz));
            check_outs($sformatf("delay idle t%0d", t), 8'hFF, 1'b1, 1'b0);
            trigger = 1'b0;
            tick    = 1'b1;
            clk1();
            if (done) ndone++;
            if (t < d) check_outs($sformatf("delay tick t%0d", t), 8'hFF, 1'b1, 1'b0);
            else       check_outs("lamps out", 8'h00, 1'b1, 1'b1);
        end
        tick = 1'b0;
        clk1();
        check_outs("after done", 8'h00, 1'b0, 1'b0);
        chk("lfsr resumes after done", 32'(lfsr_q), 32'(step7(frz)));
        for (int i = 0; i < 3; i++) begin
            clk1();
            if (done) ndone++;
        end
        chk("done pulse count", 32'(ndone), 32'd1);

        // Trigger and tick together in IDLE: the tick is dropped. The 8th
        // tick captures 06 (8 steps from seed) and freezes at 0C.
        do_reset();
        trigger = 1'b1;
        tick    = 1'b1;
        clk1();
        check_outs("trig+tick", 8'h00, 1'b1, 1'b0);
        trigger = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick = 1'b1;
            clk1();
            check_outs($sformatf("fast tick %0d", k), 8'((1 << k) - 1), 1'b1, 1'b0);
        end
        chk("fast delay lfsr", 32'(lfsr_q), 32'h0C);
        // Five of the six hold ticks: lamps stay on.
        for (int t = 1; t <= 5; t++) begin
            tick = 1'b1;
            clk1();
            check_outs($sformatf("fast hold t%0d", t), 8'hFF, 1'b1, 1'b0);
        end
        tick = 1'b0;

        // Reset in DELAY.
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        check_outs("rst in DELAY", 8'h00, 1'b0, 1'b0);
        chk("rst in DELAY lfsr_q", 32'(lfsr_q), 32'h01);
        clk1();
        chk("after rst lfsr_q", 32'(lfsr_q), 32'h02);
        check_outs("after rst", 8'h00, 1'b0, 1'b0);

`ifdef F1_DELAY_SCHED_ABORT_EN
        // Abort with a same-cycle tick in LIGHTS, then abort in DELAY.
        do_reset();
        trigger = 1'b1; clk1(); trigger = 1'b0;
        tick = 1'b1; clk1();
        tick = 1'b1; clk1();
        check_outs("abort pre", 8'h03, 1'b1, 1'b0);
        abort = 1'b1; tick = 1'b1; clk1();
        abort = 1'b0; tick = 1'b0;
        check_outs("abort in LIGHTS", 8'h00, 1'b0, 1'b0);
        trigger = 1'b1; clk1(); trigger = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick = 1'b1;
            clk1();
        end
        tick = 1'b0;
        check_outs("abort lit", 8'hFF, 1'b1, 1'b0);
        chk("abort delay lfsr", 32'(lfsr_q), 32'h42);
        abort = 1'b1; clk1(); abort = 1'b0;
        check_outs("abort in DELAY", 8'h00, 1'b0, 1'b0);
        chk("abort keeps lfsr", 32'(lfsr_q), 32'h42);
        clk1();
        chk("lfsr after abort", 32'(lfsr_q), 32'h05);
        check_outs("after abort", 8'h00, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
